// File: rtl/sha3_msg_tx_if.sv
// AXI-Stream link from the message streamer to the SHA3 core's input port.
// Carries the 16-bit data beat plus keep, last, user (mode) and ID sidebands.
interface sha3_msg_tx_if;
  logic        M_TVALID;
  logic        M_TREADY;
  logic [15:0] M_TDATA;
  logic [1:0]  M_TKEEP;
  logic        M_TLAST;
  logic [2:0]  M_TUSER;
  logic [1:0]  M_TID;

  modport master (
    output M_TVALID, M_TDATA, M_TKEEP, M_TLAST, M_TUSER, M_TID,
    input  M_TREADY
  );

  modport slave (
    input  M_TVALID, M_TDATA, M_TKEEP, M_TLAST, M_TUSER, M_TID,
    output M_TREADY
  );
endinterface

// File: rtl/sha3_msg_tx.sv
// SHA3 message streamer: host halfwords are queued in a FIFO and framed as one
// AXI-Stream message of ceil(len/2) beats per cfg_start, TLAST/TKEEP on the tail.
module sha3_msg_tx #(
  parameter int DEPTH = 16
) (
  input  logic          ACLK,
  input  logic          ARESETn,
  input  logic          cfg_start,
  input  logic [15:0]   cfg_len_bytes,
  input  logic [2:0]    cfg_user,
  input  logic [1:0]    cfg_id,
  output logic          busy,
  output logic          done,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [15:0]   wr_data,
  sha3_msg_tx_if.master m_axis
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_DONE = 2'd2} state_t;

  function automatic logic [15:0] ceil_half(input logic [15:0] len);
    return 16'(({1'b0, len} + 17'd1) >> 1);
  endfunction

  function automatic logic [15:0] frame_data(input logic [15:0] head, input logic is_final,
                                             input logic odd, input logic zero);
    if (zero) return 16'h0000;
    if (is_final && odd) return {8'h00, head[7:0]};
    return head;
  endfunction

  function automatic logic [1:0] frame_keep(input logic is_final, input logic odd, input logic zero);
    if (zero) return 2'b00;
    if (is_final && odd) return 2'b01;
    return 2'b11;
  endfunction

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          r_wr_ready;
  state_t        r_state;
  logic [15:0]   r_beats_load;
  logic          r_odd, r_zero;
  logic          r_tvalid, r_tlast;
  logic [15:0]   r_tdata;
  logic [1:0]    r_tkeep;
  logic [2:0]    r_tuser;
  logic [1:0]    r_tid;
  logic          r_busy, r_done;

  logic          w_wr, w_xfer, w_empty, w_load, w_pop, w_final;
  logic [15:0]   w_head;
  logic [AW:0]   w_count_nxt;

  assign w_wr        = wr_valid && r_wr_ready;
  assign w_xfer      = r_tvalid && m_axis.M_TREADY;
  assign w_empty     = (r_count == '0);
  assign w_final     = (r_beats_load == 16'd1);
  assign w_head      = r_mem[r_rptr];
  // A zero-length message loads one synthetic beat without touching the FIFO.
  assign w_load      = (r_state == S_SEND) && (!r_tvalid || w_xfer) &&
                       (r_beats_load != 16'd0) && (r_zero || !w_empty);
  assign w_pop       = w_load && !r_zero;
  assign w_count_nxt = r_count + (AW+1)'(w_wr) - (AW+1)'(w_pop);

  // FIFO storage
  always_ff @(posedge ACLK) begin
    if (w_wr) r_mem[r_wptr] <= wr_data;
  end

  // FIFO pointers and occupancy; wr_ready tracks the next count
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_wr_ready <= 1'b1;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count    <= w_count_nxt;
      r_wr_ready <= (w_count_nxt != FULL_CNT);
    end
  end

  // Framing FSM and output beat register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state      <= S_IDLE;
      r_beats_load <= '0;
      r_odd        <= 1'b0;
      r_zero       <= 1'b0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tdata      <= '0;
      r_tkeep      <= '0;
      r_tuser      <= '0;
      r_tid        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_load) begin
        r_tvalid     <= 1'b1;
        r_tdata      <= frame_data(w_head, w_final, r_odd, r_zero);
        r_tkeep      <= frame_keep(w_final, r_odd, r_zero);
        r_tlast      <= w_final;
        r_beats_load <= r_beats_load - 16'd1;
      end else if (w_xfer) begin
        r_tvalid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_state      <= S_SEND;
            r_busy       <= 1'b1;
            r_tuser      <= cfg_user;
            r_tid        <= cfg_id;
            r_odd        <= cfg_len_bytes[0];
            r_zero       <= (cfg_len_bytes == 16'd0);
            r_beats_load <= (cfg_len_bytes == 16'd0) ? 16'd1 : ceil_half(cfg_len_bytes);
          end
        end
        S_SEND: begin
          if (w_xfer && r_tlast) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m_axis.M_TVALID = r_tvalid;
  assign m_axis.M_TDATA  = r_tdata;
  assign m_axis.M_TKEEP  = r_tkeep;
  assign m_axis.M_TLAST  = r_tlast;
  assign m_axis.M_TUSER  = r_tuser;
  assign m_axis.M_TID    = r_tid;
  assign busy            = r_busy;
  assign done            = r_done;
  assign wr_ready        = r_wr_ready;
endmodule
